// File: rtl/mips_pkg.sv
// Shared constants and types for the multi-cycle MIPS control unit:
// FSM state encodings, opcode constants and the datapath control bundle.
package mips_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_HALT   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   // Datapath control bundle; field order matters only for packing.
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_op;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
   } ctrl_t;

   localparam ctrl_t CTRL_NONE = ctrl_t'(16'd0);

   // True when leaving state s this cycle completes an instruction.
   function automatic logic retires(input state_t s, input logic mem_ready);
      logic r;
      r = 1'b0;
      case (s)
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: r = 1'b1;
         S_MEMWR: r = mem_ready;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_opcode_decode.sv
// Opcode decoder: selects the state that follows DECODE and flags
// opcodes the control unit does not implement.
module mips_opcode_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   output state_t     next_state,
   output logic       illegal
);

   // Map each supported opcode to its first execution state; anything else halts.
   always_comb begin
      next_state = S_HALT;
      illegal    = 1'b1;
      case (opcode)
         OP_R:    begin next_state = S_EXEC;   illegal = 1'b0; end
         OP_LW:   begin next_state = S_MEMADR; illegal = 1'b0; end
         OP_SW:   begin next_state = S_MEMADR; illegal = 1'b0; end
         OP_BEQ:  begin next_state = S_BRANCH; illegal = 1'b0; end
         OP_J:    begin next_state = S_JUMP;   illegal = 1'b0; end
         OP_ADDI: begin next_state = S_ADDIEX; illegal = 1'b0; end
         default: begin next_state = S_HALT;   illegal = 1'b1; end
      endcase
   end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM driving the datapath selects,
// with a sticky illegal-opcode flag and a retired-instruction counter.
// Controls are forced to zero while reset is held so that an abandoned
// instruction cannot leave a write strobe asserted.
module mips_mc_control
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        alu_src_a,
   output logic [1:0]  alu_op,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic        illegal,
   output logic [15:0] instr_count
);

   state_t        state_r;
   state_t        next_state_s;
   state_t        dec_next_s;
   logic          dec_illegal_s;
   logic          illegal_r;
   logic [15:0]   instr_count_r;
   ctrl_t         ctrl_s;
   ctrl_t         ctrl_out_s;

   mips_opcode_decode u_decode (
      .opcode     (opcode),
      .next_state (dec_next_s),
      .illegal    (dec_illegal_s)
   );

   // State register, sticky illegal flag and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= S_FETCH;
         illegal_r     <= 1'b0;
         instr_count_r <= 16'd0;
      end else begin
         state_r <= next_state_s;
         if (state_r == S_DECODE && dec_illegal_s) begin
            illegal_r <= 1'b1;
         end
         if (retires(state_r, mem_ready)) begin
            instr_count_r <= instr_count_r + 16'd1;
         end
      end
   end

   // Next-state selection; memory states wait on mem_ready, spare codes recover to FETCH.
   always_comb begin
      next_state_s = S_FETCH;
      case (state_r)
         S_FETCH: begin
            if (mem_ready) next_state_s = S_DECODE;
            else           next_state_s = S_FETCH;
         end
         S_DECODE: next_state_s = dec_next_s;
         S_MEMADR: begin
            if (opcode == OP_SW) next_state_s = S_MEMWR;
            else                 next_state_s = S_MEMRD;
         end
         S_MEMRD: begin
            if (mem_ready) next_state_s = S_MEMWB;
            else           next_state_s = S_MEMRD;
         end
         S_MEMWB: next_state_s = S_FETCH;
         S_MEMWR: begin
            if (mem_ready) next_state_s = S_FETCH;
            else           next_state_s = S_MEMWR;
         end
         S_EXEC:   next_state_s = S_ALUWB;
         S_ALUWB:  next_state_s = S_FETCH;
         S_BRANCH: next_state_s = S_FETCH;
         S_JUMP:   next_state_s = S_FETCH;
         S_ADDIEX: next_state_s = S_ADDIWB;
         S_ADDIWB: next_state_s = S_FETCH;
         S_HALT:   next_state_s = S_HALT;
         default:  next_state_s = S_FETCH;
      endcase
   end

   // Moore control decode; only FETCH lets mem_ready gate the PC/IR strobes.
   always_comb begin
      ctrl_s = CTRL_NONE;
      case (state_r)
         S_FETCH: begin
            ctrl_s.mem_read  = 1'b1;
            ctrl_s.alu_src_b = 2'b01;
            ctrl_s.pc_write  = mem_ready;
            ctrl_s.ir_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl_s.alu_src_b = 2'b11;
         end
         S_MEMADR: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            ctrl_s.mem_read = 1'b1;
            ctrl_s.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl_s.reg_write  = 1'b1;
            ctrl_s.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl_s.mem_write = 1'b1;
            ctrl_s.i_or_d    = 1'b1;
         end
         S_EXEC: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_op    = 2'b10;
         end
         S_ALUWB: begin
            ctrl_s.reg_write = 1'b1;
            ctrl_s.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_s.alu_src_a     = 1'b1;
            ctrl_s.alu_op        = 2'b01;
            ctrl_s.pc_write_cond = 1'b1;
            ctrl_s.pc_source     = 2'b01;
         end
         S_JUMP: begin
            ctrl_s.pc_write  = 1'b1;
            ctrl_s.pc_source = 2'b10;
         end
         S_ADDIEX: begin
            ctrl_s.alu_src_a = 1'b1;
            ctrl_s.alu_src_b = 2'b10;
         end
         S_ADDIWB: begin
            ctrl_s.reg_write = 1'b1;
         end
         default: ctrl_s = CTRL_NONE;
      endcase
   end

   // Hold every control low while reset is asserted, independent of the clock.
   always_comb begin
      if (rst_n) ctrl_out_s = ctrl_s;
      else       ctrl_out_s = CTRL_NONE;
   end

   assign pc_write      = ctrl_out_s.pc_write;
   assign pc_write_cond = ctrl_out_s.pc_write_cond;
   assign i_or_d        = ctrl_out_s.i_or_d;
   assign mem_read      = ctrl_out_s.mem_read;
   assign mem_write     = ctrl_out_s.mem_write;
   assign ir_write      = ctrl_out_s.ir_write;
   assign mem_to_reg    = ctrl_out_s.mem_to_reg;
   assign reg_write     = ctrl_out_s.reg_write;
   assign reg_dst       = ctrl_out_s.reg_dst;
   assign alu_src_a     = ctrl_out_s.alu_src_a;
   assign alu_op        = ctrl_out_s.alu_op;
   assign alu_src_b     = ctrl_out_s.alu_src_b;
   assign pc_source     = ctrl_out_s.pc_source;
   assign state         = state_r;
   assign illegal       = illegal_r;
   assign instr_count   = instr_count_r;

endmodule

// File: tb/tb_mips_mc_control.sv
// Testbench for mips_mc_control: each instruction is expanded into the
// per-cycle state trace the control unit should follow (memory waits
// chosen up front), and every cycle is compared against a control table.
module tb_mips_mc_control;

   localparam int ST_FETCH  = 0;
   localparam int ST_DECODE = 1;
   localparam int ST_MEMADR = 2;
   localparam int ST_MEMRD  = 3;
   localparam int ST_MEMWB  = 4;
   localparam int ST_MEMWR  = 5;
   localparam int ST_EXEC   = 6;
   localparam int ST_ALUWB  = 7;
   localparam int ST_BRANCH = 8;
   localparam int ST_JUMP   = 9;
   localparam int ST_ADDIEX = 10;
   localparam int ST_ADDIWB = 11;
   localparam int ST_HALT   = 12;

   localparam logic [5:0] T_R    = 6'b000000;
   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_SW   = 6'b101011;
   localparam logic [5:0] T_BEQ  = 6'b000100;
   localparam logic [5:0] T_J    = 6'b000010;
   localparam logic [5:0] T_ADDI = 6'b001000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_write, reg_dst, alu_src_a;
   logic [1:0]  alu_op, alu_src_b, pc_source;
   logic [3:0]  state;
   logic        illegal;
   logic [15:0] instr_count;

   int checks    = 0;
   int failures  = 0;
   int exp_count = 0;

   mips_mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
      .alu_src_a(alu_src_a), .alu_op(alu_op), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .state(state), .illegal(illegal),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Expected controls, packed as
   // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,reg_write,reg_dst,alu_src_a,alu_op,alu_src_b,pc_source}
   function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
      logic pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa;
      logic [1:0] op, sb, ps;
      {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa} = 10'd0;
      op = 2'b00; sb = 2'b00; ps = 2'b00;
      case (s)
         ST_FETCH:  begin mrd = 1'b1; sb = 2'b01; pw = mr; irw = mr; end
         ST_DECODE: sb = 2'b11;
         ST_MEMADR: begin asa = 1'b1; sb = 2'b10; end
         ST_MEMRD:  begin mrd = 1'b1; iod = 1'b1; end
         ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
         ST_MEMWR:  begin mwr = 1'b1; iod = 1'b1; end
         ST_EXEC:   begin asa = 1'b1; op = 2'b10; end
         ST_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
         ST_BRANCH: begin asa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
         ST_JUMP:   begin pw = 1'b1; ps = 2'b10; end
         ST_ADDIEX: begin asa = 1'b1; sb = 2'b10; end
         ST_ADDIWB: rw = 1'b1;
         default:   pw = 1'b0;
      endcase
      return {pw, pwc, iod, mrd, mwr, irw, m2r, rw, rd, asa, op, sb, ps};
   endfunction

   function automatic logic [15:0] obs_ctrl();
      return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_write, reg_dst, alu_src_a, alu_op, alu_src_b, pc_source};
   endfunction

   // Run one instruction: w1 FETCH wait cycles, w2 memory-phase wait cycles.
   // Unsupported opcodes are followed for 20 cycles of HALT.
   task automatic run_instr(input logic [5:0] op, input int w1, input int w2,
                            output int n_cyc, output int n_wr);
      int   sq[$];
      logic mq[$];
      bit   legal;
      legal = 1'b1;
      for (int k = 0; k < w1; k++) begin sq.push_back(ST_FETCH); mq.push_back(1'b0); end
      sq.push_back(ST_FETCH);  mq.push_back(1'b1);
      sq.push_back(ST_DECODE); mq.push_back(1'($urandom_range(0, 1)));
      case (op)
         T_R: begin
            sq.push_back(ST_EXEC);  mq.push_back(1'($urandom_range(0, 1)));
            sq.push_back(ST_ALUWB); mq.push_back(1'($urandom_range(0, 1)));
         end
         T_LW, T_SW: begin
            sq.push_back(ST_MEMADR); mq.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k <= w2; k++) begin
               sq.push_back(op == T_LW ? ST_MEMRD : ST_MEMWR);
               mq.push_back(k == w2);
            end
            if (op == T_LW) begin
               sq.push_back(ST_MEMWB); mq.push_back(1'($urandom_range(0, 1)));
            end
         end
         T_BEQ: begin sq.push_back(ST_BRANCH); mq.push_back(1'($urandom_range(0, 1))); end
         T_J:   begin sq.push_back(ST_JUMP);   mq.push_back(1'($urandom_range(0, 1))); end
         T_ADDI: begin
            sq.push_back(ST_ADDIEX); mq.push_back(1'($urandom_range(0, 1)));
            sq.push_back(ST_ADDIWB); mq.push_back(1'($urandom_range(0, 1)));
         end
         default: begin
            legal = 1'b0;
            for (int k = 0; k < 20; k++) begin
               sq.push_back(ST_HALT); mq.push_back(1'($urandom_range(0, 1)));
            end
         end
      endcase
      n_cyc = sq.size();
      n_wr  = 0;
      foreach (sq[i]) begin
         @(negedge clk);
         mem_ready = mq[i];
         if (i == 0) opcode = op;
         #1;
         if (i == 0 || sq[i] == ST_HALT) begin
            checks++;
            if (instr_count !== 16'(exp_count)) begin
               failures++;
               $display("FAIL instr_count op=%b cyc=%0d got=%h exp=%h", op, i, instr_count, 16'(exp_count));
            end
         end
         checks++;
         if (state !== 4'(sq[i])) begin
            failures++;
            $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, i, state, sq[i]);
         end
         checks++;
         if (obs_ctrl() !== exp_ctrl(sq[i], mq[i])) begin
            failures++;
            $display("FAIL ctrl op=%b cyc=%0d st=%0d got=%b exp=%b", op, i, sq[i], obs_ctrl(), exp_ctrl(sq[i], mq[i]));
         end
         checks++;
         if (illegal !== (sq[i] == ST_HALT)) begin
            failures++;
            $display("FAIL illegal op=%b cyc=%0d got=%b exp=%b", op, i, illegal, sq[i] == ST_HALT);
         end
         checks++;
         if (mem_read && mem_write) begin
            failures++;
            $display("FAIL rd_wr_excl op=%b cyc=%0d got=11 exp=not both", op, i);
         end
         if (mem_write) n_wr++;
      end
      if (legal) exp_count = (exp_count + 1) & 16'hFFFF;
   endtask

   task automatic pulse_reset_checked(input string tag);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 16'd0 || obs_ctrl() !== 16'd0) begin
         failures++;
         $display("FAIL %s got st=%0d ill=%b cnt=%h ctrl=%b exp st=0 ill=0 cnt=0000 ctrl=0",
                  tag, state, illegal, instr_count, obs_ctrl());
      end
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n     = 1'b1;
      exp_count = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1; opcode = T_LW;
      #3;
      checks++;
      if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 16'd0 || obs_ctrl() !== 16'd0) begin
         failures++;
         $display("FAIL reset got st=%0d ill=%b cnt=%h ctrl=%b exp st=0 ill=0 cnt=0000 ctrl=0",
                  state, illegal, instr_count, obs_ctrl());
      end
      repeat (2) @(negedge clk);
      mem_ready = 1'b0;
      rst_n     = 1'b1;
      exp_count = 0;
   endtask

   task automatic test_lw();
      int n, w;
      run_instr(T_LW, 0, 0, n, w);
      checks++;
      if (n != 5) begin failures++; $display("FAIL lw_cycles got=%0d exp=5", n); end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (instr_count !== 16'd1 || state !== 4'd0) begin
         failures++;
         $display("FAIL lw_retire got cnt=%h st=%0d exp cnt=0001 st=0", instr_count, state);
      end
   endtask

   task automatic test_sw_wait();
      int n, w;
      run_instr(T_SW, 0, 3, n, w);
      checks++;
      if (n != 7 || w != 4) begin
         failures++;
         $display("FAIL sw_wait got cyc=%0d wr=%0d exp cyc=7 wr=4", n, w);
      end
   endtask

   task automatic test_beq();
      int n, w;
      run_instr(T_BEQ, 0, 0, n, w);
      checks++;
      if (n != 3) begin failures++; $display("FAIL beq_cycles got=%0d exp=3", n); end
   endtask

   task automatic test_fetch_stall();
      int n, w;
      run_instr(T_ADDI, 5, 0, n, w);
      checks++;
      if (n != 9) begin failures++; $display("FAIL fetch_stall_cycles got=%0d exp=9", n); end
   endtask

   task automatic test_random();
      logic [5:0] ops [6];
      int n, w, base;
      ops = '{T_R, T_LW, T_SW, T_BEQ, T_J, T_ADDI};
      for (int t = 0; t < 60; t++) begin
         int sel, w1, w2;
         sel = $urandom_range(0, 5);
         w1  = $urandom_range(0, 2);
         w2  = $urandom_range(0, 3);
         run_instr(ops[sel], w1, w2, n, w);
         case (ops[sel])
            T_LW:         base = 5;
            T_R, T_SW, T_ADDI: base = 4;
            default:      base = 3;
         endcase
         if (ops[sel] == T_LW || ops[sel] == T_SW) base += w2;
         checks++;
         if (n != base + w1) begin
            failures++;
            $display("FAIL cpi op=%b got=%0d exp=%0d", ops[sel], n, base + w1);
         end
      end
   endtask

   task automatic test_illegal();
      int n, w;
      run_instr(6'b111111, 0, 0, n, w);
      pulse_reset_checked("halt_reset_clear");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      opcode = T_LW; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state !== 4'd3 || mem_read !== 1'b1) begin
         failures++;
         $display("FAIL memrd_entry got st=%0d mem_read=%b exp st=3 mem_read=1", state, mem_read);
      end
      pulse_reset_checked("reset_in_memrd");
   endtask

   task automatic test_wrap();
      @(negedge clk);
      opcode = T_J; mem_ready = 1'b1;
      repeat (3 * 65535) @(negedge clk);
      #1;
      checks++;
      if (instr_count !== 16'hFFFF || state !== 4'd0) begin
         failures++;
         $display("FAIL wrap_preload got cnt=%h st=%0d exp cnt=ffff st=0", instr_count, state);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (instr_count !== 16'h0000 || state !== 4'd0) begin
         failures++;
         $display("FAIL wrap_rollover got cnt=%h st=%0d exp cnt=0000 st=0", instr_count, state);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_beq();
      test_fetch_stall();
      test_random();
      test_illegal();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports clk (rising edge) and rst_n.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  IR[31:26], valid from DECODE onward.
REQ-005 mem_ready  input  1  memory completes the current access this cycle.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  output  1 each  datapath controls.
REQ-007 alu_op, alu_src_b, pc_source  output  2 each  datapath selects.
REQ-008 state  output  4  current FSM state.
REQ-009 illegal  output  1  sticky: unsupported opcode decoded.
REQ-010 instr_count  output  16  retired-instruction counter.

Function
REQ-011 Moore FSM; outputs decoded combinationally from state, with mem_ready gating only where stated.
REQ-012 States/encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, HALT=12; 13-15 go to FETCH.
REQ-013 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; pc_write and ir_write = mem_ready; hold while mem_ready=0, else DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX, other->HALT.
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw->MEMRD, sw->MEMWR.
REQ-016 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEMWB.
REQ-017 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
REQ-018 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; ->ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; ->FETCH.
REQ-021 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; ->ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-023 HALT: all controls 0, illegal=1, remains until reset.
REQ-024 Unlisted controls 0 in every state.
REQ-025 Cycles per instruction with mem_ready=1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1.
REQ-026 instr_count increments by 1 on every transition into FETCH from MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, JUMP, ADDIWB; wraps 0xFFFF->0x0000; no increment in HALT.
REQ-027 mem_write and mem_read never both 1.

Reset
REQ-028 rst_n=0 forces state=FETCH, illegal=0, instr_count=0 immediately, independent of clk.
REQ-029 While rst_n=0 all control outputs SHALL be 0; reset mid-instruction abandons it without a write strobe.
REQ-030 First FETCH begins at the first rising clk edge after rst_n deasserts.

Structure
REQ-031 State encodings and opcode constants (R, LW, SW, BEQ, J, ADDI) SHALL live in a shared package, mips_pkg.
REQ-032 One sub-module natural: mips_opcode_decode (opcode -> next-state after DECODE, illegal flag).

Verification
REQ-033 Reset release, opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; instr_count=1.
REQ-034 opcode=101011, mem_ready low 3 cycles in MEMWR -> mem_write high 4 cycles, 7 cycles total, instr_count increments once.
REQ-035 opcode=000100 -> pc_write_cond=1, pc_source=01 in state 8; 3 cycles back to FETCH.
REQ-036 opcode=111111 -> HALT after DECODE, illegal=1, controls 0 for 20 cycles; rst_n pulse clears.
REQ-037 mem_ready=0 in FETCH for 5 cycles -> pc_write=ir_write=0 throughout, mem_read=1, state stays 0.
REQ-038 Preload instr_count=0xFFFF via 65535 j instructions, one more -> 0x0000; rst_n=0 in MEMRD -> controls 0 asynchronously, state=0.
